// File: rtl/vproc_pkg.sv
// Shared types for the vector-processor ALU arbitration slice.
package vproc_pkg;

    typedef struct packed {
        logic       first_cycle;
        logic       last_cycle;
        logic [3:0] op;
    } ctrl_t;

    typedef enum logic [1:0] {
        IDLE,
        LOCK0,
        LOCK1
    } arb_state_e;

endpackage

// File: rtl/vproc_arb_tag_fifo.sv
// Requester-id FIFO: remembers which requester owns each ALU beat in flight.
module vproc_arb_tag_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic push_tag,
    input  logic pop,
    output logic head_tag,
    output logic full,
    output logic empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] mem;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    // A full FIFO refuses a push even when a pop frees a slot this cycle.
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign head_tag = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_tag;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/vproc_alu_arbiter.sv
// Two-requester burst arbiter in front of a shared ALU; routes result valids back by tag.
module vproc_alu_arbiter
    import vproc_pkg::*;
#(
    parameter int unsigned OP_W      = 64,
    parameter type         CTRL_T    = ctrl_t,
    parameter int unsigned TAG_DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              async_rst_ni,
    input  logic [1:0]        req_valid_i,
    output logic [1:0]        req_ready_o,
    input  CTRL_T             req_ctrl_i [2],
    input  logic [OP_W-1:0]   req_op1_i  [2],
    input  logic [OP_W-1:0]   req_op2_i  [2],
    input  logic [OP_W/8-1:0] req_mask_i [2],
    output logic              alu_in_valid_o,
    input  logic              alu_in_ready_i,
    output CTRL_T             alu_in_ctrl_o,
    output logic [OP_W-1:0]   alu_in_op1_o,
    output logic [OP_W-1:0]   alu_in_op2_o,
    output logic [OP_W/8-1:0] alu_in_mask_o,
    input  logic              alu_out_valid_i,
    output logic              alu_out_ready_o,
    output logic [1:0]        res_valid_o,
    input  logic [1:0]        res_ready_i,
    output logic              err_o
);

    arb_state_e state;
    arb_state_e state_next;
    logic       rr;
    logic       rr_next;
    logic       err_next;
    logic       sel;
    logic       fire;
    logic       pop;
    logic       fifo_full;
    logic       fifo_empty;
    logic       head_tag;

    always_comb begin
        sel = 1'b0;
        unique case (state)
            LOCK0:   sel = 1'b0;
            LOCK1:   sel = 1'b1;
            default: sel = (req_valid_i == 2'b11) ? rr : req_valid_i[1];
        endcase
    end

    // Outputs are gated by the reset pin so they read 0 while reset is held.
    assign alu_in_valid_o = async_rst_ni & req_valid_i[sel] & ~fifo_full;
    assign alu_in_ctrl_o  = req_ctrl_i[sel];
    assign alu_in_op1_o   = req_op1_i[sel];
    assign alu_in_op2_o   = req_op2_i[sel];
    assign alu_in_mask_o  = req_mask_i[sel];
    assign fire           = alu_in_valid_o & alu_in_ready_i;

    always_comb begin
        req_ready_o      = '0;
        req_ready_o[sel] = async_rst_ni & alu_in_ready_i & ~fifo_full;
    end

    assign alu_out_ready_o = async_rst_ni & res_ready_i[head_tag] & ~fifo_empty;
    assign pop             = alu_out_valid_i & alu_out_ready_o;

    always_comb begin
        res_valid_o           = '0;
        res_valid_o[head_tag] = async_rst_ni & alu_out_valid_i & ~fifo_empty;
    end

    always_comb begin
        state_next = state;
        rr_next    = rr;
        err_next   = err_q_unused_guard();
        if (fire) begin
            // A beat accepted in IDLE always opens a burst, flagged or not.
            if (state == IDLE) begin
                rr_next = ~sel;
                if (!alu_in_ctrl_o.first_cycle) begin
                    err_next = 1'b1;
                end
            end
            if (alu_in_ctrl_o.last_cycle) begin
                state_next = IDLE;
            end else begin
                state_next = sel ? LOCK1 : LOCK0;
            end
        end
        if (alu_out_valid_i && fifo_empty) begin
            err_next = 1'b1;
        end
    end

    function automatic logic err_q_unused_guard();
        return err_o;
    endfunction

    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            state <= IDLE;
            rr    <= 1'b0;
            err_o <= 1'b0;
        end else begin
            state <= state_next;
            rr    <= rr_next;
            err_o <= err_next;
        end
    end

    vproc_arb_tag_fifo #(
        .DEPTH(TAG_DEPTH)
    ) u_tag_fifo (
        .clk      (clk_i),
        .rst_n    (async_rst_ni),
        .push     (fire),
        .push_tag (sel),
        .pop      (pop),
        .head_tag (head_tag),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

endmodule

// File: tb/tb_vproc_alu_arbiter.sv
// Directed scenarios plus a randomized run scored against a burst-level reference model.
module tb_vproc_alu_arbiter;
    import vproc_pkg::*;

    localparam int unsigned OP_W        = 64;
    localparam int unsigned MW          = OP_W / 8;
    localparam int unsigned DEPTH       = 4;
    localparam int          RAND_CYCLES = 6000;

    typedef struct packed {
        ctrl_t           ctrl;
        logic [OP_W-1:0] op1;
        logic [OP_W-1:0] op2;
        logic [MW-1:0]   mask;
    } beat_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    ctrl_t           req_ctrl [2];
    logic [OP_W-1:0] req_op1  [2];
    logic [OP_W-1:0] req_op2  [2];
    logic [MW-1:0]   req_mask [2];
    logic            alu_in_valid;
    logic            alu_in_ready;
    ctrl_t           alu_in_ctrl;
    logic [OP_W-1:0] alu_in_op1;
    logic [OP_W-1:0] alu_in_op2;
    logic [MW-1:0]   alu_in_mask;
    logic            alu_out_valid;
    logic            alu_out_ready;
    logic [1:0]      res_valid;
    logic [1:0]      res_ready;
    logic            err;

    int    checks = 0;
    int    errors = 0;
    logic  rand_on = 1'b0;
    logic  out_fire_seen = 1'b0;
    beat_t rq [2][$];
    bit    sb_q [$];
    int    owner_m;
    int    rr_m;
    int    exp_g;
    int    exp_h;
    int    sz0;
    beat_t exp_b;

    always #5 clk = ~clk;

    vproc_alu_arbiter #(
        .OP_W      (OP_W),
        .CTRL_T    (ctrl_t),
        .TAG_DEPTH (DEPTH)
    ) dut (
        .clk_i           (clk),
        .async_rst_ni    (rst_n),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_ctrl_i      (req_ctrl),
        .req_op1_i       (req_op1),
        .req_op2_i       (req_op2),
        .req_mask_i      (req_mask),
        .alu_in_valid_o  (alu_in_valid),
        .alu_in_ready_i  (alu_in_ready),
        .alu_in_ctrl_o   (alu_in_ctrl),
        .alu_in_op1_o    (alu_in_op1),
        .alu_in_op2_o    (alu_in_op2),
        .alu_in_mask_o   (alu_in_mask),
        .alu_out_valid_i (alu_out_valid),
        .alu_out_ready_o (alu_out_ready),
        .res_valid_o     (res_valid),
        .res_ready_i     (res_ready),
        .err_o           (err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int n, input logic v, input logic f, input logic l,
                         input logic [OP_W-1:0] op);
        req_valid[n]   = v;
        req_ctrl[n]    = '{first_cycle: f, last_cycle: l, op: 4'(n + 3)};
        req_op1[n]     = op;
        req_op2[n]     = ~op;
        req_mask[n]    = op[MW-1:0];
    endtask

    // Scoreboard monitor: the expected grant follows the burst/round-robin rules,
    // every accepted beat queues its owner, every consumed result must match the queue head.
    always @(negedge clk) begin
        if (rand_on) begin
            sz0 = sb_q.size();
            if (owner_m >= 0)              exp_g = owner_m;
            else if (req_valid == 2'b11)   exp_g = rr_m;
            else                           exp_g = req_valid[1] ? 1 : 0;
            chk("in_valid", 64'(alu_in_valid), 64'(req_valid[exp_g] && (sz0 < DEPTH)));
            if (owner_m >= 0) chk("lock_block", 64'(req_ready[1-owner_m]), 64'(0));
            out_fire_seen = 1'b0;
            if (alu_out_valid) begin
                if (sz0 == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_valid_no_tag actual=1 required=0 at %0t", $time);
                end else begin
                    exp_h = int'(sb_q[0]);
                    chk("route", 64'(res_valid), 64'(1) << exp_h);
                    chk("out_ready", 64'(alu_out_ready), 64'(res_ready[exp_h]));
                    if (alu_out_ready) begin
                        void'(sb_q.pop_front());
                        out_fire_seen = 1'b1;
                    end
                end
            end
            if (alu_in_valid && alu_in_ready) begin
                chk("grant", 64'(req_ready), 64'(1) << exp_g);
                if (rq[exp_g].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL fire_without_beat actual=%0d required=none", exp_g);
                end else begin
                    exp_b = rq[exp_g][0];
                    chk("mux_ctrl", 64'(alu_in_ctrl), 64'(exp_b.ctrl));
                    chk("mux_op1", alu_in_op1, exp_b.op1);
                    chk("mux_op2", alu_in_op2, exp_b.op2);
                    chk("mux_mask", 64'(alu_in_mask), 64'(exp_b.mask));
                    if (owner_m < 0) rr_m = 1 - exp_g;
                    owner_m = exp_b.ctrl.last_cycle ? -1 : exp_g;
                    sb_q.push_back(exp_g[0]);
                    void'(rq[exp_g].pop_front());
                end
            end
        end
    end

    initial begin
        beat_t b;
        int    len;
        int    total;

        rst_n         = 1'b0;
        alu_in_ready  = 1'b1;
        alu_out_valid = 1'b1;
        res_ready     = 2'b11;
        drive(0, 1'b1, 1'b1, 1'b1, 64'h0A);
        drive(1, 1'b1, 1'b1, 1'b1, 64'h0B);
        #12;
        chk("rst_in_valid",  64'(alu_in_valid),  64'(0));
        chk("rst_req_ready", 64'(req_ready),     64'(0));
        chk("rst_res_valid", 64'(res_valid),     64'(0));
        chk("rst_out_ready", 64'(alu_out_ready), 64'(0));
        chk("rst_err",       64'(err),           64'(0));
        alu_out_valid = 1'b0;
        req_valid     = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Round-robin on single-beat bursts, then FIFO capacity.
        drive(0, 1'b1, 1'b1, 1'b1, 64'hA0);
        drive(1, 1'b1, 1'b1, 1'b1, 64'hB0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rr_grant", 64'(req_ready), (i % 2 == 0) ? 64'd1 : 64'd2);
            chk("rr_op1", alu_in_op1, (i % 2 == 0) ? 64'hA0 : 64'hB0);
            tick();
        end
        @(negedge clk);
        chk("full_in_valid",  64'(alu_in_valid), 64'(0));
        chk("full_req_ready", 64'(req_ready),    64'(0));
        tick();
        alu_out_valid = 1'b1;
        @(negedge clk);
        chk("pop_res_valid",    64'(res_valid),     64'd1);
        chk("pop_out_ready",    64'(alu_out_ready), 64'd1);
        chk("full_during_pop",  64'(alu_in_valid),  64'd0);
        tick();
        alu_out_valid = 1'b0;
        @(negedge clk);
        chk("refill_valid", 64'(alu_in_valid), 64'd1);
        chk("refill_grant", 64'(req_ready),    64'd1);
        tick();
        @(negedge clk);
        chk("refull_valid", 64'(alu_in_valid), 64'd0);
        tick();
        req_valid     = 2'b00;
        alu_out_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("drain_route", 64'(res_valid), (i % 2 == 0) ? 64'd2 : 64'd1);
            chk("drain_ready", 64'(alu_out_ready), 64'd1);
            tick();
        end
        alu_out_valid = 1'b0;

        // Tags 0,1,0 with only requester 0 consuming.
        drive(0, 1'b1, 1'b1, 1'b1, 64'hC0);
        @(negedge clk); chk("tag0_grant", 64'(req_ready), 64'd1); tick();
        req_valid = 2'b10;
        @(negedge clk); chk("tag1_grant", 64'(req_ready), 64'd2); tick();
        req_valid = 2'b01;
        @(negedge clk); chk("tag2_grant", 64'(req_ready), 64'd1); tick();
        req_valid     = 2'b00;
        alu_out_valid = 1'b1;
        res_ready     = 2'b01;
        @(negedge clk);
        chk("r0_valid", 64'(res_valid), 64'd1);
        chk("r0_ready", 64'(alu_out_ready), 64'd1);
        tick();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("r1_stall_valid", 64'(res_valid), 64'd2);
            chk("r1_stall_ready", 64'(alu_out_ready), 64'd0);
            tick();
        end
        res_ready = 2'b11;
        @(negedge clk);
        chk("r1_go_valid", 64'(res_valid), 64'd2);
        chk("r1_go_ready", 64'(alu_out_ready), 64'd1);
        tick();
        @(negedge clk);
        chk("r2_valid", 64'(res_valid), 64'd1);
        tick();
        alu_out_valid = 1'b0;

        // Three-beat burst from requester 0 locks out requester 1.
        drive(0, 1'b1, 1'b1, 1'b0, 64'hD1);
        req_valid[1] = 1'b0;
        @(negedge clk); chk("burst_b1", 64'(req_ready), 64'd1); tick();
        drive(0, 1'b1, 1'b0, 1'b0, 64'hD2);
        drive(1, 1'b1, 1'b1, 1'b1, 64'hE1);
        @(negedge clk);
        chk("burst_b2", 64'(req_ready), 64'd1);
        chk("burst_b2_op1", alu_in_op1, 64'hD2);
        tick();
        drive(0, 1'b1, 1'b0, 1'b1, 64'hD3);
        @(negedge clk); chk("burst_b3", 64'(req_ready), 64'd1); tick();
        drive(0, 1'b1, 1'b1, 1'b1, 64'hD4);
        @(negedge clk);
        chk("after_burst_grant", 64'(req_ready), 64'd2);
        chk("after_burst_op1", alu_in_op1, 64'hE1);
        tick();
        req_valid     = 2'b00;
        alu_out_valid = 1'b1;
        res_ready     = 2'b11;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("burst_route", 64'(res_valid), (i == 3) ? 64'd2 : 64'd1);
            tick();
        end

        // Result with no tag in flight.
        @(negedge clk);
        chk("empty_out_ready", 64'(alu_out_ready), 64'd0);
        chk("err_before", 64'(err), 64'd0);
        tick();
        alu_out_valid = 1'b0;
        @(negedge clk); chk("err_set", 64'(err), 64'd1); tick();
        @(negedge clk); chk("err_held", 64'(err), 64'd1); tick();

        // Reset in the middle of a burst.
        drive(0, 1'b1, 1'b1, 1'b0, 64'hF1);
        req_valid[1] = 1'b0;
        @(negedge clk); chk("mid_start", 64'(req_ready), 64'd1); tick();
        drive(0, 1'b1, 1'b0, 1'b0, 64'hF2);
        alu_out_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_in_valid",  64'(alu_in_valid),  64'd0);
        chk("mrst_req_ready", 64'(req_ready),     64'd0);
        chk("mrst_res_valid", 64'(res_valid),     64'd0);
        chk("mrst_out_ready", 64'(alu_out_ready), 64'd0);
        chk("mrst_err",       64'(err),           64'd0);
        req_valid     = 2'b00;
        alu_out_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        drive(1, 1'b1, 1'b1, 1'b1, 64'hF3);
        alu_out_valid = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", 64'(req_ready),     64'd2);
        chk("post_rst_tags", 64'(alu_out_ready), 64'd0);
        chk("post_rst_err",  64'(err),           64'd0);
        tick();
        req_valid     = 2'b00;
        alu_out_valid = 1'b0;
        rst_n         = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Burst opened without first_cycle.
        drive(1, 1'b1, 1'b0, 1'b0, 64'h51);
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("bad_start_grant", 64'(req_ready), 64'd2);
        chk("bad_start_pre",   64'(err),       64'd0);
        tick();
        drive(0, 1'b1, 1'b1, 1'b1, 64'h52);
        drive(1, 1'b1, 1'b0, 1'b1, 64'h53);
        @(negedge clk);
        chk("bad_start_err",  64'(err),       64'd1);
        chk("bad_start_lock", 64'(req_ready), 64'd2);
        tick();

        // Randomized run.
        req_valid     = 2'b00;
        alu_out_valid = 1'b0;
        rst_n         = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 2; n++) begin
            total = 0;
            while (total < 120) begin
                len = int'($urandom_range(1, 4));
                for (int k = 0; k < len; k++) begin
                    b.ctrl.first_cycle = (k == 0);
                    b.ctrl.last_cycle  = (k == len - 1);
                    b.ctrl.op          = 4'($urandom);
                    b.op1              = {$urandom, $urandom};
                    b.op2              = {$urandom, $urandom};
                    b.mask             = MW'($urandom);
                    rq[n].push_back(b);
                end
                total += len;
            end
        end
        owner_m = -1;
        rr_m    = 0;
        tick();
        rand_on = 1'b1;
        for (int c = 0; c < RAND_CYCLES; c++) begin
            @(posedge clk);
            #1;
            if (out_fire_seen) alu_out_valid = 1'b0;
            if (!alu_out_valid) alu_out_valid = (sb_q.size() > 0) && ($urandom_range(0, 2) != 0);
            alu_in_ready = ($urandom_range(0, 3) != 0);
            res_ready    = 2'($urandom);
            for (int n = 0; n < 2; n++) begin
                if (rq[n].size() > 0) begin
                    b           = rq[n][0];
                    req_ctrl[n] = b.ctrl;
                    req_op1[n]  = b.op1;
                    req_op2[n]  = b.op2;
                    req_mask[n] = b.mask;
                    req_valid[n] = ($urandom_range(0, 4) != 0);
                end else begin
                    req_valid[n] = 1'b0;
                end
            end
            if (rq[0].size() == 0 && rq[1].size() == 0 && sb_q.size() == 0) break;
        end
        rand_on = 1'b0;
        chk("rand_drained", 64'(rq[0].size() + rq[1].size() + sb_q.size()), 64'd0);
        chk("rand_err_clean", 64'(err), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vproc_alu_arbiter.md
VPROC_ALU_ARBITER -- requirements
Module: vproc_alu_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  OP_W  64  operand width, equal to the ALU operand width.
  CTRL_T  ctrl_t  per-beat control struct type.
  TAG_DEPTH  4  maximum number of ALU beats in flight; power of two, >=2.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk_i  in  1  single clock.
  async_rst_ni  in  1  reset, asynchronous, active-low.
  req_valid_i  in  2  per-requester beat valid.
  req_ready_o  out  2  per-requester beat accepted.
  req_ctrl_i  in  2xCTRL_T  per-requester control.
  req_op1_i, req_op2_i  in  2xOP_W  per-requester operands.
  req_mask_i  in  2xOP_W/8  per-requester byte mask.
  alu_in_valid_o  out  1  beat to ALU valid.
  alu_in_ready_i  in  1  ALU accepts beat.
  alu_in_ctrl_o, alu_in_op1_o, alu_in_op2_o, alu_in_mask_o  out  CTRL_T/OP_W/OP_W/OP_W/8  muxed beat.
  alu_out_valid_i  in  1  ALU result valid.
  alu_out_ready_o  out  1  result consumed.
  res_valid_o  out  2  result valid, routed to its originating requester.
  res_ready_i  in  2  requester consumes result.
  err_o  out  1  sticky protocol-error flag.
REQ-003 ALU result data fields SHALL NOT pass through this block; consumers tap the ALU outputs directly.

Function
REQ-004 A burst SHALL be the sequence of beats from ctrl.first_cycle through ctrl.last_cycle; a single beat may carry both flags.
REQ-005 FSM states SHALL be IDLE, LOCK0, LOCK1.
REQ-006 In IDLE the block SHALL select the sole valid requester, or, when both are valid, the one indicated by the round-robin pointer rr.
REQ-007 On a fire (alu_in_valid_o & alu_in_ready_i) in IDLE, rr SHALL toggle to the non-granted requester.
REQ-008 On fire: last_cycle=1 -> IDLE; last_cycle=0 -> LOCKn, where n is the granted requester.
REQ-009 In LOCKn only requester n SHALL be forwarded; the other requester's req_ready_o SHALL be 0, and the FSM SHALL return to IDLE on the fire of the beat with last_cycle=1.
REQ-010 alu_in_* SHALL be a zero-latency combinational mux of the selected requester; alu_in_valid_o = selected req_valid_i & !fifo_full.
REQ-011 req_ready_o[n] SHALL equal alu_in_ready_i & !fifo_full & (n selected).
REQ-012 alu_in_valid_o SHALL have no combinational dependence on alu_in_ready_i.
REQ-013 Each fire SHALL push the requester id into the tag FIFO; each alu_out fire (alu_out_valid_i & alu_out_ready_o) SHALL pop it.
REQ-014 Occupancy counter width SHALL be $clog2(TAG_DEPTH+1).
REQ-015 When the FIFO is full, push SHALL be blocked even if a pop occurs in the same cycle; push and pop in the same cycle when not full SHALL leave the count unchanged.
REQ-016 res_valid_o[head] SHALL equal alu_out_valid_i, and the other bit SHALL be 0.
REQ-017 alu_out_ready_o SHALL equal res_ready_i[head] & !fifo_empty.
REQ-018 alu_out_valid_i=1 while the FIFO is empty SHALL set err_o, and alu_out_ready_o SHALL stay 0.
REQ-019 A beat fired in IDLE with first_cycle=0 SHALL set err_o, and the beat SHALL still be treated as a burst start.
REQ-020 err_o SHALL be cleared only by reset.

Reset
REQ-021 Asynchronous reset SHALL force FSM=IDLE, rr=0, FIFO empty, err_o=0, alu_in_valid_o=0, req_ready_o=0, res_valid_o=0, alu_out_ready_o=0.
REQ-022 Reset asserted mid-burst or with beats in flight SHALL discard all tags; the ALU SHALL be reset on the same reset.

Structure
REQ-023 ctrl_t and the FSM state enum SHALL live in the shared package (vproc_pkg / synth_pkg); TAG_DEPTH SHALL be a module parameter.
REQ-024 The tag FIFO SHALL be a sub-module vproc_arb_tag_fifo, 1-bit data, depth TAG_DEPTH.

Verification
REQ-025 Both requesters valid in IDLE with single-beat bursts, after reset -> grants in order 0,1,0,1 on consecutive fires.
REQ-026 Requester 0 issues a 3-beat burst (first, mid, last) while requester 1 is continuously valid -> req_ready_o[1]=0 until beat 3 fires; requester 1 is granted next.
REQ-027 alu_out_ready_i... alu_out never consumed with TAG_DEPTH=4 -> exactly 4 fires, then alu_in_valid_o=0; one pop -> exactly one further fire.
REQ-028 Tags 0,1,0 in flight with res_ready_i=2'b01 -> res_valid_o=2'b01, then 2'b10 stalls with alu_out_ready_o=0 until res_ready_i[1]=1.
REQ-029 alu_out_valid_i=1 with an empty FIFO -> err_o=1 next cycle and held; reset asserted mid-burst -> all outputs 0, FSM=IDLE.
